// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, op type and shifter helpers.
// ALU_SHIFT_ROT_EN adds the rotate ops to the supported set.
package alu_pkg;

  typedef logic [4:0] alu_op_t;

  localparam alu_op_t ALU_OP_SLL = 5'd8;
  localparam alu_op_t ALU_OP_SRL = 5'd12;
  localparam alu_op_t ALU_OP_SRA = 5'd13;
  localparam alu_op_t ALU_OP_ROL = 5'd14;
  localparam alu_op_t ALU_OP_ROR = 5'd15;

  function automatic int shift_bits_per_stage(input int shamt_w, input int stages);
    return (shamt_w + stages - 32'sd1) / stages;
  endfunction

  function automatic logic op_supported(input alu_op_t op);
    logic ok;
    case (op)
      ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA: ok = 1'b1;
`ifdef ALU_SHIFT_ROT_EN
      ALU_OP_ROL, ALU_OP_ROR:             ok = 1'b1;
`endif
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_shift_pipe_if.sv
// Request/result bundle of the pipelined shifter, including the flush strobe.
interface alu_shift_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  import alu_pkg::*;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  alu_op_t           in_op;
  logic [XLEN-1:0]   in_dat1;
  logic [XLEN-1:0]   in_dat2;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_data;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output flush, in_valid, in_op, in_dat1, in_dat2, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  flush, in_valid, in_op, in_dat1, in_dat2, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/alu_shift_stage.sv
// Combinational partial shift applying shamt bits [LO_BIT +: N_BITS].
// Rotate paths exist only when ALU_SHIFT_ROT_EN is defined.
module alu_shift_stage
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int LO_BIT = 0,
  parameter int N_BITS = 1
) (
  input  alu_op_t           op,
  input  logic              sign,
  input  logic [N_BITS-1:0] grp,
  input  logic [XLEN-1:0]   din,
  output logic [XLEN-1:0]   dout
);

  int amt_s;

  // Log-shifter: each set shamt bit moves the word by its power of two
  always_comb begin
    dout  = din;
    amt_s = 32'sd0;
    for (int b = 0; b < N_BITS; b++) begin
      amt_s = 32'sd1 << (LO_BIT + b);
      if (grp[b]) begin
        case (op)
          ALU_OP_SLL: dout = dout << amt_s;
          ALU_OP_SRL: dout = dout >> amt_s;
          ALU_OP_SRA: dout = (dout >> amt_s) | ({XLEN{sign}} << (XLEN - amt_s));
`ifdef ALU_SHIFT_ROT_EN
          ALU_OP_ROL: dout = (dout << amt_s) | (dout >> (XLEN - amt_s));
          ALU_OP_ROR: dout = (dout >> amt_s) | (dout << (XLEN - amt_s));
`endif
          default:    dout = dout;
        endcase
      end else begin
        dout = dout;
      end
    end
  end

endmodule

// File: rtl/alu_shift_pipe.sv
// Pipelined logarithmic shifter (SLL/SRL/SRA) with valid/ready, flush and tag.
// Define ALU_SHIFT_ROT_EN to add ROL/ROR in the same pipeline.
module alu_shift_pipe
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN),
  parameter int STAGES  = 2,
  parameter int TAG_W   = 4
) (
  input  logic              soc_clk,
  input  logic              reset,
  alu_shift_pipe_if.slave   bus
);

  localparam int BPS = shift_bits_per_stage(SHAMT_W, STAGES);

  logic              advance_s;

  logic              vld_in_s   [STAGES];
  logic              sign_in_s  [STAGES];
  alu_op_t           op_in_s    [STAGES];
  logic [XLEN-1:0]   dat_in_s   [STAGES];
  logic [XLEN-1:0]   dat_sh_s   [STAGES];
  logic [SHAMT_W-1:0] shamt_in_s [STAGES];
  logic [TAG_W-1:0]  tag_in_s   [STAGES];

  logic              vld_r   [STAGES];
  logic              sign_r  [STAGES];
  alu_op_t           op_r    [STAGES];
  logic [XLEN-1:0]   dat_r   [STAGES];
  logic [SHAMT_W-1:0] shamt_r [STAGES];
  logic [TAG_W-1:0]  tag_r   [STAGES];

  // A stalled output freezes the whole pipe; otherwise every slot moves
  assign advance_s     = ~vld_r[STAGES-1] | bus.out_ready;
  assign bus.in_ready  = advance_s;
  assign bus.out_valid = vld_r[STAGES-1];
  assign bus.out_data  = dat_r[STAGES-1];
  assign bus.out_tag   = tag_r[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * BPS;
    localparam int NB = (LO >= SHAMT_W) ? 0 : (((SHAMT_W - LO) < BPS) ? (SHAMT_W - LO) : BPS);

    if (k == 0) begin : g_src
      assign vld_in_s[k]   = bus.in_valid;
      assign sign_in_s[k]  = bus.in_dat1[XLEN-1];
      assign op_in_s[k]    = bus.in_op;
      assign dat_in_s[k]   = bus.in_dat1;
      assign shamt_in_s[k] = bus.in_dat2[SHAMT_W-1:0];
      assign tag_in_s[k]   = bus.in_tag;
    end else begin : g_src
      assign vld_in_s[k]   = vld_r[k-1];
      assign sign_in_s[k]  = sign_r[k-1];
      assign op_in_s[k]    = op_r[k-1];
      assign dat_in_s[k]   = dat_r[k-1];
      assign shamt_in_s[k] = shamt_r[k-1];
      assign tag_in_s[k]   = tag_r[k-1];
    end

    if (NB > 0) begin : g_shift
      alu_shift_stage #(
        .XLEN   (XLEN),
        .LO_BIT (LO),
        .N_BITS (NB)
      ) u_stage (
        .op   (op_in_s[k]),
        .sign (sign_in_s[k]),
        .grp  (shamt_in_s[k][LO +: NB]),
        .din  (dat_in_s[k]),
        .dout (dat_sh_s[k])
      );
    end else begin : g_pass
      assign dat_sh_s[k] = dat_in_s[k];
    end

    if (k == STAGES - 1) begin : g_last
      // Output slot: data and tag are forced to zero whenever no valid result sits here
      always_ff @(posedge soc_clk) begin
        if (reset || bus.flush) begin
          vld_r[k]   <= 1'b0;
          sign_r[k]  <= 1'b0;
          op_r[k]    <= 5'd0;
          dat_r[k]   <= {XLEN{1'b0}};
          shamt_r[k] <= {SHAMT_W{1'b0}};
          tag_r[k]   <= {TAG_W{1'b0}};
        end else if (advance_s) begin
          vld_r[k]   <= vld_in_s[k];
          sign_r[k]  <= sign_in_s[k];
          op_r[k]    <= op_in_s[k];
          dat_r[k]   <= (vld_in_s[k] && op_supported(op_in_s[k])) ? dat_sh_s[k] : {XLEN{1'b0}};
          shamt_r[k] <= shamt_in_s[k];
          tag_r[k]   <= vld_in_s[k] ? tag_in_s[k] : {TAG_W{1'b0}};
        end else begin
          vld_r[k]   <= vld_r[k];
          sign_r[k]  <= sign_r[k];
          op_r[k]    <= op_r[k];
          dat_r[k]   <= dat_r[k];
          shamt_r[k] <= shamt_r[k];
          tag_r[k]   <= tag_r[k];
        end
      end
    end else begin : g_mid
      // Intermediate slot: flush only needs to kill the valid bit
      always_ff @(posedge soc_clk) begin
        if (reset) begin
          vld_r[k]   <= 1'b0;
          sign_r[k]  <= 1'b0;
          op_r[k]    <= 5'd0;
          dat_r[k]   <= {XLEN{1'b0}};
          shamt_r[k] <= {SHAMT_W{1'b0}};
          tag_r[k]   <= {TAG_W{1'b0}};
        end else if (bus.flush) begin
          vld_r[k]   <= 1'b0;
        end else if (advance_s) begin
          vld_r[k]   <= vld_in_s[k];
          sign_r[k]  <= sign_in_s[k];
          op_r[k]    <= op_in_s[k];
          dat_r[k]   <= dat_sh_s[k];
          shamt_r[k] <= shamt_in_s[k];
          tag_r[k]   <= tag_in_s[k];
        end else begin
          vld_r[k]   <= vld_r[k];
        end
      end
    end
  end

endmodule
